// File: rtl/serial_feeder.sv
// serial_feeder: parallel-to-serial shifter, LSB first, with a one-word pending buffer
// so back-to-back words leave with no idle bit between them.
module serial_feeder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             pause,
  output logic             dout,
  output logic             dout_valid,
  output logic             word_done,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  typedef enum logic {IDLE, SHIFT} state_e;
  state_e           state_q;
  logic [WIDTH-1:0] shift_q, pend_q;
  logic             pend_full_q;
  logic [CW-1:0]    cnt_q;
  logic             accept;
  assign load_ready = ~pend_full_q;
  assign accept     = load_valid & load_ready;
  assign dout_valid = state_q == SHIFT;
  assign dout       = dout_valid & shift_q[0];
  assign word_done  = dout_valid && cnt_q == LAST && !pause;
  assign busy       = dout_valid | pend_full_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      pend_q      <= '0;
      pend_full_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          shift_q <= load_data;
          cnt_q   <= '0;
          state_q <= SHIFT;
        end
        SHIFT: if (word_done) begin
          // pending word wins; otherwise a word arriving on the last bit goes straight in
          if (pend_full_q) begin
            shift_q     <= pend_q;
            pend_full_q <= 1'b0;
            cnt_q       <= '0;
          end else if (accept) begin
            shift_q <= load_data;
            cnt_q   <= '0;
          end else begin
            state_q <= IDLE;
          end
        end else begin
          if (!pause) begin
            shift_q <= shift_q >> 1;
            cnt_q   <= cnt_q + 1'b1;
          end
          if (accept) begin
            pend_q      <= load_data;
            pend_full_q <= 1'b1;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_feeder.sv
// tb_serial_feeder: table, directed and random checks of serial_feeder (WIDTH=8)
// against a word-queue reference model.
module tb_serial_feeder;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic load_valid = 1'b0;
  logic [W-1:0] load_data = '0;
  logic pause = 1'b0;
  logic load_ready, dout, dout_valid, word_done, busy;
  int n_chk = 0;
  int n_fail = 0;
  logic [W-1:0] mq[$];
  int pos = 0;
  logic [63:0] col;
  int ncol;
  serial_feeder #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .pause(pause), .dout(dout), .dout_valid(dout_valid),
    .word_done(word_done), .busy(busy)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic         lv;
    logic [W-1:0] d;
    logic         p;
    logic         e_dout, e_dv, e_wd, e_rdy, e_busy;
  } vec_t;
  vec_t tbl[10];
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Model: queue of accepted words not yet fully sent; head is on the wire at bit pos.
  task automatic check_model();
    logic [W-1:0] w;
    logic e_dout;
    w = mq.size() > 0 ? mq[0] : '0;
    e_dout = mq.size() > 0 ? w[pos] : 1'b0;
    chk("dout", dout, e_dout);
    chk("dout_valid", dout_valid, mq.size() > 0);
    chk("word_done", word_done, mq.size() > 0 && pos == W - 1 && !pause);
    chk("busy", busy, mq.size() > 0);
    chk("load_ready", load_ready, mq.size() < 2);
    if (dout_valid && !pause) begin
      col[ncol] = dout;
      ncol++;
    end
  endtask
  task automatic model_step();
    logic acc;
    acc = load_valid && mq.size() < 2;
    if (mq.size() > 0 && !pause) begin
      pos++;
      if (pos == W) begin
        void'(mq.pop_front());
        pos = 0;
      end
    end
    if (acc) mq.push_back(load_data);
  endtask
  task automatic apply(input logic lv, input logic [W-1:0] d, input logic p);
    load_valid = lv;
    load_data  = d;
    pause      = p;
    @(negedge clk);
    check_model();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic clr_col();
    col  = '0;
    ncol = 0;
  endtask
  initial begin
    logic [63:0] stream;
    logic [W-1:0] b4;
    int k;
    b4 = 8'hB4;
    tbl[0] = '{1'b1, 8'hB4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 1; i <= 8; i++)
      tbl[i] = '{1'b0, 8'h00, 1'b0, b4[i-1], 1'b1, i == 8, 1'b1, 1'b1};
    tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    #3;
    chk("rst_dout", dout, 1'b0);
    chk("rst_dv", dout_valid, 1'b0);
    chk("rst_wd", word_done, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_ready", load_ready, 1'b1);
    #4 rst = 1'b1;
    @(posedge clk);
    #1;
    // 8'hB4 from IDLE
    for (int i = 0; i < 10; i++) begin
      load_valid = tbl[i].lv;
      load_data  = tbl[i].d;
      pause      = tbl[i].p;
      @(negedge clk);
      chk($sformatf("tbl%0d_dout", i), dout, tbl[i].e_dout);
      chk($sformatf("tbl%0d_dv", i), dout_valid, tbl[i].e_dv);
      chk($sformatf("tbl%0d_wd", i), word_done, tbl[i].e_wd);
      chk($sformatf("tbl%0d_rdy", i), load_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_busy", i), busy, tbl[i].e_busy);
      @(posedge clk);
      model_step();
      #1;
    end
    // 0F then F0 during bit 1: pending handoff, no gap
    clr_col();
    apply(1'b1, 8'h0F, 1'b0);
    apply(1'b0, 8'h00, 1'b0);
    apply(1'b1, 8'hF0, 1'b0);
    for (int i = 0; i < 16; i++) apply(1'b0, 8'h00, 1'b0);
    chk("pend_stream", col[15:0], 16'hF00F);
    chk("pend_nbits", ncol, 16);
    // AA then 55 on the word_done edge with pending empty
    clr_col();
    apply(1'b1, 8'hAA, 1'b0);
    for (int i = 0; i < 7; i++) apply(1'b0, 8'h00, 1'b0);
    chk("wd_edge_wd", word_done, 1'b1);
    apply(1'b1, 8'h55, 1'b0);
    chk("wd_edge_ready", load_ready, 1'b1);
    for (int i = 0; i < 9; i++) apply(1'b0, 8'h00, 1'b0);
    chk("wd_edge_stream", col[15:0], 16'h55AA);
    // FF with a 5-cycle pause after bit 3
    clr_col();
    apply(1'b1, 8'hFF, 1'b0);
    for (int i = 0; i < 4; i++) apply(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 8'h00, 1'b1);
      chk("pause_dout", dout, 1'b1);
      chk("pause_dv", dout_valid, 1'b1);
    end
    for (int i = 0; i < 6; i++) apply(1'b0, 8'h00, 1'b0);
    chk("pause_nbits", ncol, 8);
    chk("pause_idle", dout_valid, 1'b0);
    // async reset during bit 4 of 3C with C3 pending
    clr_col();
    apply(1'b1, 8'h3C, 1'b0);
    apply(1'b0, 8'h00, 1'b0);
    apply(1'b1, 8'hC3, 1'b0);
    apply(1'b0, 8'h00, 1'b0);
    apply(1'b0, 8'h00, 1'b0);
    chk("pre_rst_ready", load_ready, 1'b0);
    #2 rst = 1'b0;
    #1;
    chk("arst_dout", dout, 1'b0);
    chk("arst_dv", dout_valid, 1'b0);
    chk("arst_wd", word_done, 1'b0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_ready", load_ready, 1'b1);
    mq.delete();
    pos = 0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    clr_col();
    for (int i = 0; i < 10; i++) apply(1'b0, 8'h00, 1'b0);
    chk("arst_no_c3", ncol, 0);
    apply(1'b1, 8'h5A, 1'b0);
    for (int i = 0; i < 9; i++) apply(1'b0, 8'h00, 1'b0);
    chk("post_rst_stream", col[7:0], 8'h5A);
    // 64-bit detector stream, continuous valid
    clr_col();
    stream = 64'h3B55_6A8D_955A_AAAA;
    k = 0;
    for (int c = 0; c < 100 && k < 8; c++) begin
      logic go;
      go = mq.size() < 2;
      apply(1'b1, stream[8*k +: 8], 1'b0);
      if (go) k++;
    end
    chk("stream_loaded", k, 8);
    for (int i = 0; i < 20; i++) apply(1'b0, 8'h00, 1'b0);
    chk("stream_bits", col, stream);
    chk("stream_nbits", ncol, 64);
    // random traffic
    for (int i = 0; i < 600; i++)
      apply(1'($urandom_range(0, 1)), 8'($urandom), $urandom_range(0, 3) == 0);
    for (int i = 0; i < 20; i++) apply(1'b0, 8'h00, 1'b0);
    chk("rand_drained", busy, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/serial_feeder.md
SERIAL_FEEDER -- requirements
Module: serial_feeder

Interface
REQ-001 The block SHALL take parameter WIDTH, default 64, meaning the parallel word length in bits (legal range 2..256).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 load_valid  input  1  upstream offers load_data this cycle.
REQ-005 load_data  input  WIDTH  parallel word to serialize; bit 0 is sent first.
REQ-006 load_ready  output  1  block accepts a word at the next rising edge.
REQ-007 pause  input  1  freezes the shift pipeline while high.
REQ-008 dout  output  1  serial bit that drives a downstream detector's din.
REQ-009 dout_valid  output  1  dout carries a real data bit.
REQ-010 word_done  output  1  the current dout is the last bit of its word and advances at the next edge.
REQ-011 busy  output  1  a word is shifting or a word is pending.

Function
REQ-012 The block SHALL contain a WIDTH-bit shift register, a one-word pending register with a full flag, and a bit counter of ceil(log2(WIDTH))+1 bits.
REQ-013 A word SHALL be accepted exactly on a rising edge where load_valid=1 and load_ready=1.
REQ-014 load_ready SHALL equal NOT pending_full, with no dependence on load_valid.
REQ-015 FSM states SHALL be IDLE and SHIFT.
REQ-016 In IDLE, an accepted word SHALL load directly into the shift register and clear the counter, and the FSM SHALL enter SHIFT; bit 0 appears on dout in the cycle after the accepting edge (latency 1).
REQ-017 In SHIFT, a word accepted while the pending register is empty SHALL be stored in the pending register, except as stated in REQ-021.
REQ-018 In SHIFT with pause=0 and counter<WIDTH-1, each edge SHALL shift the register right by one and increment the counter.
REQ-019 word_done SHALL be combinational: state=SHIFT AND counter=WIDTH-1 AND pause=0.
REQ-020 At an edge with word_done=1 and pending_full=1, the pending word SHALL move to the shift register, pending_full SHALL clear, the counter SHALL go to 0, and the FSM SHALL stay in SHIFT with no idle bit between words.
REQ-021 At an edge with word_done=1, pending_full=0 and a word accepted on that same edge, the word SHALL load directly into the shift register, the FSM SHALL stay in SHIFT, and pending SHALL remain empty.
REQ-022 At an edge with word_done=1, pending empty and no word accepted, the FSM SHALL return to IDLE.
REQ-023 With pause=1, the shift register, counter and FSM state SHALL hold, dout and dout_valid SHALL stay stable, and loads into an empty pending register SHALL still be accepted.
REQ-024 A pause asserted in IDLE SHALL NOT block a load; the serial bits SHALL then start with bit 0 held until pause falls.
REQ-025 dout_valid SHALL be 1 exactly when state=SHIFT, and dout SHALL equal shift_reg[0] when dout_valid=1 and 0 otherwise.
REQ-026 busy SHALL equal (state=SHIFT) OR pending_full.
REQ-027 Exactly WIDTH unpaused cycles of dout_valid SHALL occur per accepted word, and words SHALL leave in acceptance order.

Reset
REQ-028 When rst=0 the block SHALL immediately clear the state to IDLE, the counter to 0, the shift register to 0, the pending register to 0 and pending_full to 0, independent of clk.
REQ-029 During reset the outputs SHALL be dout=0, dout_valid=0, word_done=0, busy=0 and load_ready=1.
REQ-030 A reset that arrives mid-word SHALL discard both the in-flight word and the pending word, and the first edge after rst=1 SHALL accept a load normally.

Verification (WIDTH=8)
REQ-031 The bench SHALL load 8'hB4 from IDLE and check that dout equals 0,0,1,0,1,1,0,1 on consecutive cycles, that word_done is high only on the eighth bit, and that the FSM is in IDLE afterwards.
REQ-032 The bench SHALL load 8'h0F and then, during the second bit, 8'hF0, and check that load_ready=0 until the handoff and that the 16-bit stream 1111_0000_0000_1111 (LSB first) appears with no gap.
REQ-033 The bench SHALL load 8'hAA and, with pending empty, assert load_valid with 8'h55 on the word_done edge, and check that the 8'h55 bits follow with no gap and pending_full stays 0.
REQ-034 The bench SHALL load 8'hFF and hold pause=1 for 5 cycles after bit 3, and check that dout=1 and dout_valid=1 are held with the counter frozen, and that exactly 8 valid unpaused bits are produced in total.
REQ-035 The bench SHALL drive rst=0 off-edge during bit 4 of 8'h3C with 8'hC3 pending, and check that all outputs go to 0 and load_ready to 1 immediately, and that 8'hC3 is never emitted.
REQ-036 The bench SHALL drive the detector pair with the 64-bit stream 0x3B55_6A8D_955A_AAAA through the feeder, and check that dout matches the stream bit-for-bit, LSB first.
